// File: rtl/down_count_timer.sv
// Loadable down counter with terminal-count pulse, used as a delay/timeout timer.
// Optional periodic reload build: define DOWN_COUNT_TIMER_AUTO_RELOAD_EN.
module down_count_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             zero,
   output logic             tc
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state;

`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_reg;
`endif

   // State, count, busy and tc all advance together; load has priority over counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         busy  <= 1'b0;
         tc    <= 1'b0;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
         reload_reg <= '0;
`endif
      end else begin
         tc <= 1'b0;
         if (load) begin
            count <= load_val;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
            reload_reg <= load_val;
`endif
            if (load_val != '0) begin
               state <= RUN;
               busy  <= 1'b1;
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else begin
            case (state)
               RUN: begin
                  if (en) begin
                     if (count == WIDTH'(1)) begin
                        tc <= 1'b1;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                        count <= reload_reg;
`else
                        // One-shot: settle at zero and stop; never wraps.
                        count <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                     end else begin
                        count <= count - WIDTH'(1);
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign zero = (count == '0);

endmodule
